uart_hex_collector: RTL and testbench

Parametrised ASCII-hex command collector sitting between the UART receiver and the user logic. Consumes the received byte stream, assembles up to DIGIT_COUNT hexadecimal digits in typed order (first digit = most significant), supports line editing (backspace, escape), and delivers the assembled value with a one-cycle strobe on Enter or, optionally, automatically when the buffer fills. Flags invalid characters and overflow.

---
 rtl/uart_hex_collector.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_hex_collector.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_collector.sv
// uart_hex_collector: assembles typed ASCII-hex digits into a value, with backspace/escape
// editing and a one-cycle commit strobe. Define UART_HEX_ECHO_EN to add the UART echo path.
module uart_hex_collector #(
   parameter int DIGIT_COUNT = 4,
   parameter bit AUTO_COMMIT = 1'b0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [7:0]                       rx_data,
   input  logic                             rx_valid,
   output logic [4*DIGIT_COUNT-1:0]         out,
   output logic [$clog2(DIGIT_COUNT+1)-1:0] out_digits,
   output logic                             ready_out,
   output logic                             err_char,
   output logic                             err_ovf,
   input  logic                             err_clr
`ifdef UART_HEX_ECHO_EN
   ,
   output logic [7:0]                       tx_data,
   output logic                             tx_valid,
   input  logic                             tx_ready
`endif
);

   localparam int W  = 4 * DIGIT_COUNT;
   localparam int CW = $clog2(DIGIT_COUNT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DIGIT_COUNT);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      COLLECT = 2'd1,
      FULL    = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      CLS_DIGIT = 3'd0,
      CLS_ENTER = 3'd1,
      CLS_BKSP  = 3'd2,
      CLS_ESC   = 3'd3,
      CLS_BAD   = 3'd4
   } cls_t;

   function automatic cls_t classify(input logic [7:0] b);
      cls_t c;
      if ((b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
          (b >= 8'h61 && b <= 8'h66)) begin
         c = CLS_DIGIT;
      end else if (b == 8'h0D || b == 8'h0A) begin
         c = CLS_ENTER;
      end else if (b == 8'h08 || b == 8'h7F) begin
         c = CLS_BKSP;
      end else if (b == 8'h1B) begin
         c = CLS_ESC;
      end else begin
         c = CLS_BAD;
      end
      return c;
   endfunction

   // Letters 'A'..'F' / 'a'..'f' carry 1..6 in their low nibble.
   function automatic logic [3:0] hex_nibble(input logic [7:0] b);
      logic [3:0] n;
      if (b <= 8'h39) begin
         n = b[3:0];
      end else begin
         n = b[3:0] + 4'd9;
      end
      return n;
   endfunction

   state_t          state_r, state_nxt;
   logic [W-1:0]    buf_r, buf_nxt, shifted_s, commit_val_s;
   logic [CW-1:0]   cnt_r, cnt_nxt, cnt_inc_s, commit_cnt_s;
   cls_t            cls_s;
   logic            commit_s, set_char_s, set_ovf_s;
   logic [W-1:0]    out_r;
   logic [CW-1:0]   digits_r;
   logic            ready_r, err_char_r, err_ovf_r;

   assign cls_s     = classify(rx_data);
   assign shifted_s = (buf_r << 4) | W'(hex_nibble(rx_data));
   assign cnt_inc_s = cnt_r + ONE_CNT;

   // Collection state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= EMPTY;
         buf_r   <= {W{1'b0}};
         cnt_r   <= {CW{1'b0}};
      end else begin
         state_r <= state_nxt;
         buf_r   <= buf_nxt;
         cnt_r   <= cnt_nxt;
      end
   end

   // Next-state, buffer editing and commit/flag events
   always_comb begin
      state_nxt    = state_r;
      buf_nxt      = buf_r;
      cnt_nxt      = cnt_r;
      commit_s     = 1'b0;
      commit_val_s = buf_r;
      commit_cnt_s = cnt_r;
      set_char_s   = 1'b0;
      set_ovf_s    = 1'b0;
      if (rx_valid) begin
         case (cls_s)
            CLS_DIGIT: begin
               if (state_r == FULL) begin
                  set_ovf_s = 1'b1;
               end else if (cnt_inc_s == FULL_CNT && AUTO_COMMIT == 1'b1) begin
                  commit_s     = 1'b1;
                  commit_val_s = shifted_s;
                  commit_cnt_s = cnt_inc_s;
                  buf_nxt      = {W{1'b0}};
                  cnt_nxt      = {CW{1'b0}};
                  state_nxt    = EMPTY;
               end else if (cnt_inc_s == FULL_CNT) begin
                  buf_nxt   = shifted_s;
                  cnt_nxt   = cnt_inc_s;
                  state_nxt = FULL;
               end else begin
                  buf_nxt   = shifted_s;
                  cnt_nxt   = cnt_inc_s;
                  state_nxt = COLLECT;
               end
            end
            CLS_ENTER: begin
               if (state_r != EMPTY) begin
                  commit_s  = 1'b1;
                  buf_nxt   = {W{1'b0}};
                  cnt_nxt   = {CW{1'b0}};
                  state_nxt = EMPTY;
               end else begin
                  state_nxt = state_r;
               end
            end
            CLS_BKSP: begin
               if (state_r != EMPTY) begin
                  buf_nxt   = buf_r >> 4;
                  cnt_nxt   = cnt_r - ONE_CNT;
                  state_nxt = (cnt_r == ONE_CNT) ? EMPTY : COLLECT;
               end else begin
                  state_nxt = state_r;
               end
            end
            CLS_ESC: begin
               buf_nxt   = {W{1'b0}};
               cnt_nxt   = {CW{1'b0}};
               state_nxt = EMPTY;
            end
            CLS_BAD: begin
               set_char_s = 1'b1;
            end
            default: begin
               state_nxt = state_r;
            end
         endcase
      end else begin
         state_nxt = state_r;
      end
   end

   // Committed value, strobe and sticky error flags (a setting event beats err_clr)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_r      <= {W{1'b0}};
         digits_r   <= {CW{1'b0}};
         ready_r    <= 1'b0;
         err_char_r <= 1'b0;
         err_ovf_r  <= 1'b0;
      end else begin
         if (commit_s) begin
            out_r    <= commit_val_s;
            digits_r <= commit_cnt_s;
         end else begin
            out_r    <= out_r;
            digits_r <= digits_r;
         end
         ready_r    <= commit_s;
         err_char_r <= set_char_s | (err_char_r & ~err_clr);
         err_ovf_r  <= set_ovf_s  | (err_ovf_r  & ~err_clr);
      end
   end

   assign out        = out_r;
   assign out_digits = digits_r;
   assign ready_out  = ready_r;
   assign err_char   = err_char_r;
   assign err_ovf    = err_ovf_r;

`ifdef UART_HEX_ECHO_EN
   logic       echo_s;
   logic [7:0] echo_byte_s;
   logic [7:0] tx_data_r;
   logic       tx_valid_r;

   // Echo only bytes that actually changed the entry; ignored or dropped bytes stay silent
   always_comb begin
      echo_s      = 1'b0;
      echo_byte_s = rx_data;
      if (rx_valid) begin
         case (cls_s)
            CLS_DIGIT: begin
               echo_s      = (state_r != FULL);
               echo_byte_s = rx_data;
            end
            CLS_ENTER: begin
               echo_s      = (state_r != EMPTY);
               echo_byte_s = 8'h0D;
            end
            CLS_BKSP: begin
               echo_s      = (state_r != EMPTY);
               echo_byte_s = 8'h08;
            end
            default: begin
               echo_s = 1'b0;
            end
         endcase
      end else begin
         echo_s = 1'b0;
      end
   end

   // One-entry echo holding register; new echoes are dropped while it is occupied
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_data_r  <= 8'h00;
         tx_valid_r <= 1'b0;
      end else if (tx_valid_r) begin
         tx_valid_r <= ~tx_ready;
         tx_data_r  <= tx_data_r;
      end else if (echo_s) begin
         tx_valid_r <= 1'b1;
         tx_data_r  <= echo_byte_s;
      end else begin
         tx_valid_r <= 1'b0;
         tx_data_r  <= tx_data_r;
      end
   end

   assign tx_data  = tx_data_r;
   assign tx_valid = tx_valid_r;
`endif

endmodule

// File: tb/tb_uart_hex_collector.sv
// Scoreboard bench: unit A (DIGIT_COUNT=4, Enter commit) and unit B (DIGIT_COUNT=2, auto commit).
module tb_uart_hex_collector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [7:0]  rxd_a, rxd_b;
   logic        rxv_a, rxv_b, clr_a, clr_b;
   logic [15:0] out_a;
   logic [2:0]  dig_a;
   logic        rdy_a, ec_a, eo_a;
   logic [7:0]  out_b;
   logic [1:0]  dig_b;
   logic        rdy_b, ec_b, eo_b;
`ifdef UART_HEX_ECHO_EN
   logic [7:0]  txd_a, txd_b;
   logic        txv_a, txv_b;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [15:0] v;
      int          d;
      int          c;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   uart_hex_collector #(.DIGIT_COUNT(4), .AUTO_COMMIT(1'b0)) dut_a (
      .clk(clk), .reset(reset), .rx_data(rxd_a), .rx_valid(rxv_a),
      .out(out_a), .out_digits(dig_a), .ready_out(rdy_a),
      .err_char(ec_a), .err_ovf(eo_a), .err_clr(clr_a)
`ifdef UART_HEX_ECHO_EN
      , .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(1'b1)
`endif
   );

   uart_hex_collector #(.DIGIT_COUNT(2), .AUTO_COMMIT(1'b1)) dut_b (
      .clk(clk), .reset(reset), .rx_data(rxd_b), .rx_valid(rxv_b),
      .out(out_b), .out_digits(dig_b), .ready_out(rdy_b),
      .err_char(ec_b), .err_ovf(eo_b), .err_clr(clr_b)
`ifdef UART_HEX_ECHO_EN
      , .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(1'b1)
`endif
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitors: every strobe must match the oldest expected commit, value and cycle
   always @(negedge clk) begin
      if (rdy_a !== 1'b0) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_strobe", 64'(rdy_a), 64'd0);
         end else begin
            exp_t e;
            e = q_a.pop_front();
            check("a_out", 64'(out_a), 64'(e.v));
            check("a_digits", 64'(dig_a), 64'(e.d));
            check("a_latency", 64'(cyc), 64'(e.c));
         end
      end
   end

   always @(negedge clk) begin
      if (rdy_b !== 1'b0) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_strobe", 64'(rdy_b), 64'd0);
         end else begin
            exp_t e;
            e = q_b.pop_front();
            check("b_out", 64'(out_b), 64'(e.v));
            check("b_digits", 64'(dig_b), 64'(e.d));
            check("b_latency", 64'(cyc), 64'(e.c));
         end
      end
   end

   task automatic send_a(input logic [7:0] b);
      rxd_a = b;
      rxv_a = 1'b1;
      @(negedge clk);
      rxv_a = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      rxd_b = b;
      rxv_b = 1'b1;
      @(negedge clk);
      rxv_b = 1'b0;
   endtask

   task automatic str_a(input string s);
      for (int i = 0; i < s.len(); i++) send_a(s[i]);
   endtask

   task automatic exp_a(input logic [15:0] v, input int d);
      exp_t e;
      e.v = v; e.d = d; e.c = cyc + 1;
      q_a.push_back(e);
   endtask

   task automatic exp_b(input logic [15:0] v, input int d);
      exp_t e;
      e.v = v; e.d = d; e.c = cyc + 1;
      q_b.push_back(e);
   endtask

   initial begin
      reset = 1'b1;
      rxd_a = 8'h00; rxv_a = 1'b0; clr_a = 1'b0;
      rxd_b = 8'h00; rxv_b = 1'b0; clr_b = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_a", 64'(out_a), 64'd0);
      check("rst_dig_a", 64'(dig_a), 64'd0);
      check("rst_rdy_a", 64'(rdy_a), 64'd0);
      check("rst_ec_a", 64'(ec_a), 64'd0);
      check("rst_eo_a", 64'(eo_a), 64'd0);
      check("rst_out_b", 64'(out_b), 64'd0);
      check("rst_dig_b", 64'(dig_b), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      str_a("1a3F"); exp_a(16'h1A3F, 4); send_a(8'h0D);
      str_a("12"); send_a(8'h08); str_a("5"); exp_a(16'h0015, 2); send_a(8'h0D);

      str_a("12345");
      check("a_ovf_set", 64'(eo_a), 64'd1);
      check("a_char_clear", 64'(ec_a), 64'd0);
      exp_a(16'h1234, 4); send_a(8'h0D);
      clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
      check("a_ovf_cleared", 64'(eo_a), 64'd0);

      str_a("7G"); send_a(8'h1B); send_a(8'h0D);
      check("a_char_set", 64'(ec_a), 64'd1);
      check("a_out_held", 64'(out_a), 64'h1234);
      check("a_dig_held", 64'(dig_a), 64'd4);

      send_a(8'h08); str_a("9"); exp_a(16'h0009, 1); send_a(8'h0A);

      clr_a = 1'b1; send_a(8'h5A); clr_a = 1'b0;
      check("a_set_wins", 64'(ec_a), 64'd1);
      clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
      check("a_char_cleared", 64'(ec_a), 64'd0);

      str_a("ffff"); exp_a(16'hFFFF, 4); send_a(8'h0D);
      send_a(8'h7F); str_a("b"); send_a(8'h7F); send_a(8'h0D);
      check("a_bksp_to_empty", 64'(out_a), 64'hFFFF);

      send_b(8'h61); exp_b(16'h00AB, 2); send_b(8'h62); send_b(8'h63);
      check("b_flags", 64'({ec_b, eo_b}), 64'd0);
      send_a(8'h35);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_out_a", 64'(out_a), 64'd0);
      check("mid_rst_dig_a", 64'(dig_a), 64'd0);
      check("mid_rst_out_b", 64'(out_b), 64'd0);
      check("mid_rst_dig_b", 64'(dig_b), 64'd0);
      check("mid_rst_rdy_b", 64'(rdy_b), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      send_a(8'h0D);
      send_b(8'h64); exp_b(16'h000D, 1); send_b(8'h0D);
      repeat (3) @(negedge clk);

      check("a_queue_drained", 64'(q_a.size()), 64'd0);
      check("b_queue_drained", 64'(q_b.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
